// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Brief    : Shared types and constants for the fetch/data memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  // Returns {fetch_ack, data_ack} for the owner of a finishing access.
  function automatic logic [1:0] owner_ack(input logic done, input logic owner);
    logic [1:0] ack;
    ack = 2'b00;
    if (done) begin
      ack = (owner == OWN_DATA) ? 2'b01 : 2'b10;
    end
    return ack;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_arbiter_if
// Brief     : Fetch, load/store and memory-port signals of the memory arbiter.
// Revision  : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int WIDTH = mem_arb_pkg::DEFAULT_WIDTH
);

  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic             i_ack;
  logic [WIDTH-1:0] i_rdata;

  logic             d_req;
  logic             d_wr;
  logic             d_byte;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_ack;
  logic [WIDTH-1:0] d_rdata;

  logic             mem_wr;
  logic             mem_byte;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic             busy;

  // Arbiter side
  modport slave (
    input  i_req, i_addr,
    input  d_req, d_wr, d_byte, d_addr, d_wdata,
    input  mem_rdata,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output mem_wr, mem_byte, mem_addr, mem_wdata,
    output busy
  );

  // Requesters and memory side
  modport master (
    output i_req, i_addr,
    output d_req, d_wr, d_byte, d_addr, d_wdata,
    output mem_rdata,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  mem_wr, mem_byte, mem_addr, mem_wdata,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick2
// Brief    : Two-input request picker; MEM_ARB_ROUND_ROBIN_EN selects round-robin,
//            otherwise the data port has fixed priority.
// Revision : 1.0  initial release
// ============================================================================
module arb_pick2
  import mem_arb_pkg::*;
(
  input  wire logic i_req,
  input  wire logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  wire logic last,
`endif
  output logic      owner
);

  always_comb begin
    owner = OWN_FETCH;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      owner = ~last;
`else
      owner = OWN_DATA;
`endif
    end else if (d_req) begin
      owner = OWN_DATA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between fetch and load/store, one access per
//            3-cycle window. Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_arbiter_if.slave bus
);

  arb_state_e       r_state;
  arb_state_e       w_state_next;

  logic             w_grant;
  logic             w_pick;
  logic             w_done;
  logic [1:0]       w_ack;

  logic             r_owner;
  logic             r_store;
  logic             r_mem_wr;
  logic             r_mem_byte;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;

  assign w_grant = (r_state == IDLE) && (bus.i_req || bus.d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  arb_pick2 u_pick (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .last  (r_last),
    .owner (w_pick)
  );

  // Resets to data so that fetch wins the first conflict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= OWN_DATA;
    end else if (w_grant) begin
      r_last <= w_pick;
    end
  end
`else
  arb_pick2 u_pick (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .owner (w_pick)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_next = ACCESS;
      ACCESS:  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Payload is captured once at grant; later requester changes never reach memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner     <= OWN_FETCH;
      r_store     <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_byte  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_wr <= 1'b0;
      if (w_grant) begin
        r_owner <= w_pick;
        if (w_pick == OWN_DATA) begin
          r_store     <= bus.d_wr;
          r_mem_wr    <= bus.d_wr;
          r_mem_byte  <= bus.d_byte;
          r_mem_addr  <= bus.d_addr;
          r_mem_wdata <= bus.d_wdata;
        end else begin
          r_store     <= 1'b0;
          r_mem_byte  <= 1'b0;
          r_mem_addr  <= bus.i_addr;
        end
      end
    end
  end

  assign w_done = (r_state == DONE);
  assign w_ack  = owner_ack(w_done, r_owner);

  assign bus.i_ack     = w_ack[1];
  assign bus.d_ack     = w_ack[0];
  assign bus.i_rdata   = w_ack[1] ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (w_ack[0] && !r_store) ? bus.mem_rdata : '0;

  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_byte  = r_mem_byte;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with a byte-addressed memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int W = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  mem_arbiter_if #(.WIDTH(W)) bus ();

  mem_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory contents before any write
  function automatic logic [7:0] init_byte(input logic [7:0] a);
    logic [31:0] w0;
    int          idx;
    w0  = 32'h00500093;
    idx = int'(a) - 16;
    if (idx >= 0 && idx < 4) return w0[idx*8 +: 8];
    return a * 8'd7 + 8'd3;
  endfunction

  logic [7:0] mem   [256];
  bit         wmask [256];

  function automatic logic [7:0] mbyte(input logic [7:0] a);
    return wmask[a] ? mem[a] : init_byte(a);
  endfunction

  // Memory model: registered read one cycle after the address, write on the edge
  always @(posedge clk) begin
    logic [7:0] a;
    a = bus.mem_addr[7:0];
    if (bus.mem_byte) bus.mem_rdata <= {24'h0, mbyte(a)};
    else              bus.mem_rdata <= {mbyte(a + 8'd3), mbyte(a + 8'd2), mbyte(a + 8'd1), mbyte(a)};
    if (bus.mem_wr) begin
      if (bus.mem_byte) begin
        mem[a]   <= bus.mem_wdata[7:0];
        wmask[a] <= 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          mem[a + 8'(k)]   <= bus.mem_wdata[8*k +: 8];
          wmask[a + 8'(k)] <= 1'b1;
        end
      end
    end
  end

  // Reference view of memory, updated only by accesses the bench expects to commit
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] ref_rd(input logic [7:0] a, input logic byt);
    if (byt) return {24'h0, ref_mem[a]};
    return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
  endfunction

  function automatic void ref_wr(input logic [7:0] a, input logic byt, input logic [31:0] d);
    if (byt) ref_mem[a] = d[7:0];
    else for (int k = 0; k < 4; k++) ref_mem[a + 8'(k)] = d[8*k +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    #4 rst = 1'b1;
    tick();
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    bit          byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [1:0]  exp_ack;
    bit          ip, dp, i_done, d_done, ei, ed;
    int          free_from, ack_at;
    logic        own_q, last_g;
    logic [31:0] data_q;

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'h00500093};
    vt[1] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'h43, 32'hAB,       32'h0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,        32'hABADBEEF};
    vt[5] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0,        32'hABADBEEF};

    for (int a = 0; a < 256; a++) ref_mem[a] = init_byte(8'(a));

    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_byte  = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset values
    tick();
    check("rst i_ack",     32'(bus.i_ack),    32'h0);
    check("rst d_ack",     32'(bus.d_ack),    32'h0);
    check("rst i_rdata",   bus.i_rdata,       32'h0);
    check("rst d_rdata",   bus.d_rdata,       32'h0);
    check("rst mem_wr",    32'(bus.mem_wr),   32'h0);
    check("rst mem_byte",  32'(bus.mem_byte), 32'h0);
    check("rst mem_addr",  bus.mem_addr,      32'h0);
    check("rst mem_wdata", bus.mem_wdata,     32'h0);
    check("rst busy",      32'(bus.busy),     32'h0);
    #4 rst = 1'b1;
    tick();

    // Single transactions from a table
    for (int v = 0; v < 6; v++) begin
      if (vt[v].is_d) begin
        bus.d_req   = 1'b1;
        bus.d_wr    = vt[v].wr;
        bus.d_byte  = vt[v].byt;
        bus.d_addr  = vt[v].addr;
        bus.d_wdata = vt[v].wdata;
      end else begin
        bus.i_req  = 1'b1;
        bus.i_addr = vt[v].addr;
      end
      tick();
      check($sformatf("v%0d mem_addr", v), bus.mem_addr, vt[v].addr);
      check($sformatf("v%0d mem_wr", v),   32'(bus.mem_wr), 32'(vt[v].wr));
      check($sformatf("v%0d mem_byte", v), 32'(bus.mem_byte), 32'(vt[v].is_d & vt[v].byt));
      check($sformatf("v%0d busy_acc", v), 32'(bus.busy), 32'h1);
      if (vt[v].wr) check($sformatf("v%0d mem_wdata", v), bus.mem_wdata, vt[v].wdata);
      tick();
      check($sformatf("v%0d mem_wr_done", v), 32'(bus.mem_wr), 32'h0);
      check($sformatf("v%0d acks", v), 32'({bus.i_ack, bus.d_ack}), vt[v].is_d ? 32'h1 : 32'h2);
      check($sformatf("v%0d rdata", v), vt[v].is_d ? bus.d_rdata : bus.i_rdata, vt[v].exp_rdata);
      tick();
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      check($sformatf("v%0d busy_end", v), 32'(bus.busy), 32'h0);
      if (vt[v].wr) ref_wr(vt[v].addr[7:0], vt[v].byt, vt[v].wdata);
      tick();
    end

    // Conflict: both ports held high
    reset_dut();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h10;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_byte = 1'b0;
    bus.d_addr = 32'h40;
    for (int k = 0; k < 9; k++) begin
      if (k == 2 || k == 8) exp_ack = RR ? 2'b10 : 2'b01;
      else if (k == 5)      exp_ack = 2'b01;
      else                  exp_ack = 2'b00;
      check($sformatf("conflict acks c%0d", k), 32'({bus.i_ack, bus.d_ack}), 32'(exp_ack));
      tick();
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    tick();

    // Early drop of d_req after grant
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 32'h40;
    tick();
    bus.d_req  = 1'b0;
    bus.d_addr = 32'h10;
    check("drop busy c1", 32'(bus.busy), 32'h1);
    tick();
    check("drop d_ack c2",   32'(bus.d_ack), 32'h1);
    check("drop d_rdata c2", bus.d_rdata, ref_rd(8'h40, 1'b0));
    tick();
    check("drop busy c3", 32'(bus.busy), 32'h0);
    tick();

    // Reset during the ACCESS cycle of a store
    reset_dut();
    bus.d_req   = 1'b1;
    bus.d_wr    = 1'b1;
    bus.d_byte  = 1'b0;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'h12345678;
    tick();
    check("rstmid mem_wr pre", 32'(bus.mem_wr), 32'h1);
    rst       = 1'b0;
    bus.d_req = 1'b0;
    #1;
    check("rstmid mem_wr", 32'(bus.mem_wr), 32'h0);
    check("rstmid busy",   32'(bus.busy),   32'h0);
    tick();
    check("rstmid acks a", 32'({bus.i_ack, bus.d_ack}), 32'h0);
    #4 rst = 1'b1;
    tick();
    check("rstmid acks b", 32'({bus.i_ack, bus.d_ack}), 32'h0);
    bus.d_req = 1'b1;
    bus.d_wr  = 1'b0;
    tick();
    tick();
    check("rstmid load ack",   32'(bus.d_ack), 32'h1);
    check("rstmid load rdata", bus.d_rdata, ref_rd(8'h80, 1'b0));
    tick();
    bus.d_req = 1'b0;
    tick();

    // Randomized traffic against a window-level scheduling model
    reset_dut();
    ip = 0; dp = 0; i_done = 0; d_done = 0;
    free_from = 0;
    ack_at    = -1;
    own_q     = OWN_FETCH;
    last_g    = OWN_DATA;
    data_q    = '0;
    for (int c = 0; c < 900; c++) begin
      ei = (ack_at == c) && (own_q == OWN_FETCH);
      ed = (ack_at == c) && (own_q == OWN_DATA);
      check("rnd acks",    32'({bus.i_ack, bus.d_ack}), 32'({ei, ed}));
      check("rnd i_rdata", bus.i_rdata, ei ? data_q : 32'h0);
      check("rnd d_rdata", bus.d_rdata, ed ? data_q : 32'h0);
      check("rnd busy",    32'(bus.busy), 32'(c >= free_from - 2 && c < free_from));

      if (i_done) begin bus.i_req = 1'b0; ip = 0; end
      if (d_done) begin bus.d_req = 1'b0; dp = 0; end
      i_done = ei;
      d_done = ed;
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip         = 1;
        bus.i_req  = 1'b1;
        bus.i_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp          = 1;
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'($urandom_range(0, 1));
        bus.d_byte  = 1'($urandom_range(0, 1));
        bus.d_addr  = bus.d_byte ? {24'h0, 8'($urandom_range(0, 255))}
                                 : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        bus.d_wdata = $urandom;
      end

      if (c >= free_from && (ip || dp)) begin
        if (ip && dp) own_q = RR ? ~last_g : OWN_DATA;
        else          own_q = dp ? OWN_DATA : OWN_FETCH;
        last_g    = own_q;
        ack_at    = c + 2;
        free_from = c + 3;
        if (own_q == OWN_FETCH) begin
          data_q = ref_rd(bus.i_addr[7:0], 1'b0);
        end else if (bus.d_wr) begin
          data_q = 32'h0;
          ref_wr(bus.d_addr[7:0], bus.d_byte, bus.d_wdata);
        end else begin
          data_q = ref_rd(bus.d_addr[7:0], bus.d_byte);
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory_byte` instance between the instruction-fetch path and the load/store data path of the RISC-V core. It accepts at most one request per access window, drives the memory port from registered outputs, and returns read data plus a one-cycle acknowledge to the winning requester. The arbiter sits between the PC/fetch logic and the data-access logic on one side and the memory on the other.

## Interface
- `WIDTH`, 32, address and data width.
- `clk  in  1  clock`, rising-edge.
- `rst  in  1  reset`, asynchronous, active-low.
- `i_req  in  1  fetch request`, held until `i_ack`.
- `i_addr  in  WIDTH  fetch byte address`.
- `i_ack  out  1  fetch done`, one-cycle pulse.
- `i_rdata  out  WIDTH  fetch data`, valid only with `i_ack`, otherwise 0.
- `d_req  in  1  data request`, held until `d_ack`.
- `d_wr  in  1  1 = store, 0 = load`.
- `d_byte  in  1  byte access`, passed through to the memory.
- `d_addr  in  WIDTH  data byte address`.
- `d_wdata  in  WIDTH  store data`.
- `d_ack  out  1  data done`, one-cycle pulse.
- `d_rdata  out  WIDTH  load data`, valid with `d_ack` on loads, otherwise 0.
- `mem_wr  out  1  memory write enable`.
- `mem_byte  out  1  memory byte mode`.
- `mem_addr  out  WIDTH  memory address`.
- `mem_wdata  out  WIDTH  memory write data`.
- `mem_rdata  in  WIDTH  memory read data`, registered inside the memory, valid the cycle after the address is applied.
- `busy  out  1  state != IDLE`.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If no requests are pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, the arbitration policy decides (see Configuration).
  - On the grant edge: latch addr, wdata, wr and byte into the `mem_*` registers, record the owner, go to ACCESS.
- **ACCESS**
  - `mem_*` outputs are stable.
  - The memory performs the write, or captures the read, at the closing edge.
  - `mem_wr` is cleared on that edge. Go to DONE.
- **DONE**
  - Pulse the owner's ack.
  - Owner's rdata = `mem_rdata` (forced 0 for stores).
  - Go to IDLE.
- Fetch requests are always reads. `mem_byte` is forced 0 for fetch.
- Requesters hold `req` and their payload stable from assertion through the ack cycle.
  - They deassert or re-issue in the cycle after ack.
  - A req still high in IDLE after its ack is treated as a new request.
- Payload changes after grant are ignored; the latched copy is used.
- If `req` drops before ack (protocol violation), the access still completes and the ack still pulses.
- `mem_addr`, `mem_wdata` and `mem_byte` hold their last values in IDLE. `mem_wr` is 1 only in ACCESS.

## Timing
- Request seen in IDLE at cycle N: ACCESS at N+1, ack at N+2, IDLE at N+3.
- Peak throughput is one access per 3 cycles.
- Acks are mutually exclusive; at most one is asserted per cycle.
- Reset value of every output is 0, and the FSM resets to IDLE.
- Reset asserted mid-ACCESS:
  - `mem_wr` drops immediately (asynchronously), so no write commits after the reset edge.
  - The in-flight access is discarded and no ack is issued.
- The last-grant register resets to "data", so fetch wins the first conflict.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, grant the port not granted most recently.
  - The last-grant register updates on every grant.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the data port always wins a conflict.
  - The last-grant register is absent.
- With either setting, uncontested requests are granted immediately.

## Structure
- Shared package `mem_arb_pkg` contains:
  - state enum (IDLE, ACCESS, DONE);
  - owner constants `OWN_FETCH = 1'b0`, `OWN_DATA = 1'b1`;
  - the default `WIDTH`.
- One sub-module, `arb_pick2`, is natural: a two-input picker.
  - Inputs: `i_req`, `d_req`, `last`.
  - Output: `owner`.
  - Contains the macro-selected policy.
- The FSM and datapath registers stay in `mem_arbiter`.

## Test plan
- **Single fetch:** `i_req=1`, `i_addr=0x10` at cycle 0, with memory word 0x10 = 0x00500093.
  - Expect `mem_addr=0x10` in cycle 1, `i_ack=1` and `i_rdata=0x00500093` in cycle 2.
  - `busy` is 0 in cycle 3.
- **Store then load:** `d_req`, `d_wr=1`, `d_addr=0x40`, `d_wdata=0xDEADBEEF`.
  - Expect `mem_wr=1` only in cycle 1 and `d_ack` in cycle 2 with `d_rdata=0`.
  - A following load from 0x40 returns 0xDEADBEEF with its `d_ack`.
- **Conflict:** `i_req` and `d_req` both held high continuously.
  - Round-robin build: grants alternate fetch, data, fetch, with acks at cycles 2, 5 and 8.
  - Fixed build: data is granted every window and fetch never is.
- **Byte store:** `d_byte=1`, `d_addr=0x43`, `d_wdata=0xAB`.
  - Expect `mem_byte=1` during ACCESS.
  - A subsequent word load of 0x40 shows only byte 3 changed to 0xAB.
- **Reset mid-access:** assert `rst=0` during the ACCESS of a store to 0x80.
  - Expect `mem_wr=0` immediately and no ack.
  - After release, a load of 0x80 returns the pre-store value.
- **Early drop:** `d_req` deasserted in cycle 1 after grant.
  - `d_ack` still pulses in cycle 2.
  - The arbiter returns to IDLE, and `busy` is 0 in cycle 3.
